conv_window_buffer: RTL and testbench

Parametrised sliding-window line buffer for the convolution stage. It accepts one IFM pixel per enabled cycle in raster order, keeps the last `(KERNAL_SIZE-1)*IFM_SIZE + KERNAL_SIZE` pixels in a shift chain, and presents all `KERNAL_SIZE*KERNAL_SIZE` window taps in parallel. It adds row/column tracking, a stride-aware window-valid strobe and an end-of-frame pulse, so the MAC array downstream needs no address logic.

---
 rtl/conv_window_buffer.sv | 144 ++++++++++++++
 tb/tb_conv_window_buffer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_buffer.sv
// conv_window_buffer
// Sliding-window line buffer for the convolution stage. Pixels arrive one per
// enabled cycle in raster order and shift through a chain deep enough to hold
// KERNAL_SIZE-1 full rows plus KERNAL_SIZE pixels. All KERNAL_SIZE*KERNAL_SIZE
// taps are presented in parallel. Row/column tracking produces a stride-aware
// window_valid strobe and a frame_done pulse on the last window of a frame.
//
// Optional feature macro: FIFO_RESET_CLEAR_EN
//   defined   -> reset also zeroes the storage, so taps read 0 after reset
//   undefined -> reset clears only counters and flags; storage keeps its data
//
// Handshake: there is no back-pressure. window_valid is a one-cycle strobe that
// marks window_data_out as a complete, stride-aligned window; the taps then hold
// until the next cycle with fifo_enable high, so the consumer must capture them
// in the strobe cycle or before the next enabled cycle.

module conv_window_buffer #(
    parameter int DATA_WIDTH    = 16,
    parameter int IFM_SIZE      = 28,
    parameter int KERNAL_SIZE   = 3,
    parameter int STRIDE        = 1,
    parameter int FIFO_SIZE     = (KERNAL_SIZE - 1) * IFM_SIZE + KERNAL_SIZE,
    parameter int IFM_SIZE_NEXT = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        fifo_enable,
    input  logic [DATA_WIDTH-1:0]                       fifo_data_in,
    output logic [KERNAL_SIZE*KERNAL_SIZE*DATA_WIDTH-1:0] window_data_out,
    output logic                                        window_valid,
    output logic                                        frame_done
);

    localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] POS_LAST      = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0] POS_FIRST_WIN = CW'(KERNAL_SIZE - 1);
    localparam logic [CW-1:0] POS_LAST_WIN  = CW'(KERNAL_SIZE - 1 + (IFM_SIZE_NEXT - 1) * STRIDE);
    localparam logic [PW-1:0] PHASE_LAST    = PW'(STRIDE - 1);

    logic [DATA_WIDTH-1:0] fifo [FIFO_SIZE];

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [PW-1:0] col_phase;
    logic [PW-1:0] row_phase;

    logic col_win;
    logic row_win;
    logic col_wrap;
    logic row_wrap;
    logic win_hit;
    logic last_hit;

    // Window / wrap decode for the pixel being accepted this cycle
    always_comb begin
        col_win  = (col >= POS_FIRST_WIN);
        row_win  = (row >= POS_FIRST_WIN);
        col_wrap = (col == POS_LAST);
        row_wrap = (row == POS_LAST);
        win_hit  = fifo_enable && col_win && row_win &&
                   (col_phase == '0) && (row_phase == '0);
        last_hit = win_hit && (col == POS_LAST_WIN) && (row == POS_LAST_WIN);
    end

    // Position counters and per-axis stride phases; phases count only once the
    // axis has reached its first window position, so phase 0 marks an aligned spot
    always_ff @(posedge clk) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            col_phase <= '0;
            row_phase <= '0;
        end else if (fifo_enable) begin
            if (col_wrap) begin
                col       <= '0;
                col_phase <= '0;
                if (row_wrap) begin
                    row       <= '0;
                    row_phase <= '0;
                end else begin
                    row <= row + CW'(1);
                    if (row_win)
                        row_phase <= (row_phase == PHASE_LAST) ? '0 : row_phase + PW'(1);
                    else
                        row_phase <= '0;
                end
            end else begin
                col <= col + CW'(1);
                if (col_win)
                    col_phase <= (col_phase == PHASE_LAST) ? '0 : col_phase + PW'(1);
                else
                    col_phase <= '0;
            end
        end
    end

    // Registered strobes; both drop after one cycle because win_hit needs fifo_enable
    always_ff @(posedge clk) begin
        if (reset) begin
            window_valid <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= win_hit;
            frame_done   <= last_hit;
        end
    end

`ifdef FIFO_RESET_CLEAR_EN
    // Shift chain, cleared on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_SIZE; i++)
                fifo[i] <= '0;
        end else if (fifo_enable) begin
            fifo[0] <= fifo_data_in;
            for (int i = 1; i < FIFO_SIZE; i++)
                fifo[i] <= fifo[i-1];
        end
    end
`else
    // Shift chain without reset; a pixel presented during reset is dropped
    always_ff @(posedge clk) begin
        if (fifo_enable && !reset) begin
            fifo[0] <= fifo_data_in;
            for (int i = 1; i < FIFO_SIZE; i++)
                fifo[i] <= fifo[i-1];
        end
    end
`endif

    // Tap (r,c) reads the entry that arrived (K-1-r) rows and (K-1-c) pixels ago
    always_comb begin
        window_data_out = '0;
        for (int r = 0; r < KERNAL_SIZE; r++) begin
            for (int c = 0; c < KERNAL_SIZE; c++) begin
                window_data_out[(r*KERNAL_SIZE + c)*DATA_WIDTH +: DATA_WIDTH] =
                    fifo[(KERNAL_SIZE-1-r)*IFM_SIZE + (KERNAL_SIZE-1-c)];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_buffer.sv
// Bench for conv_window_buffer: two instances (stride 1 and stride 2) on a
// 5x5 frame with a 3x3 kernel share one input stream. A frame-image model
// predicts valid/done strobes and window contents.

module tb_conv_window_buffer;

    localparam int DW  = 16;
    localparam int IFM = 5;
    localparam int K   = 3;
    localparam int TW  = K*K*DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_enable = 1'b0;
    logic [DW-1:0] fifo_data_in = '0;
    logic [TW-1:0] taps1, taps2;
    logic          valid1, valid2, done1, done2;

    conv_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(1)) dut1 (
        .clk(clk), .reset(reset), .fifo_enable(fifo_enable), .fifo_data_in(fifo_data_in),
        .window_data_out(taps1), .window_valid(valid1), .frame_done(done1));

    conv_window_buffer #(.DATA_WIDTH(DW), .IFM_SIZE(IFM), .KERNAL_SIZE(K), .STRIDE(2)) dut2 (
        .clk(clk), .reset(reset), .fifo_enable(fifo_enable), .fifo_data_in(fifo_data_in),
        .window_data_out(taps2), .window_valid(valid2), .frame_done(done2));

    // clock
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // frame model state
    logic [DW-1:0] img [IFM][IFM];
    int            pix = 0;
    logic [TW-1:0] exp_q [$];
    logic [TW-1:0] prev1, prev2;

    // per-section statistics
    int n_v1, n_v2, n_d1, n_d2, acc_cnt, first_v1, mix_bad;
    logic [TW-1:0] first_taps1;

    typedef struct {
        logic [DW-1:0] data;
        logic          v1;
        logic          v2;
        logic          done;
    } vec_t;
    vec_t tbl [25];

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_const(input string name, input logic [TW-1:0] act, input int v[9]);
        logic [TW-1:0] e;
        e = '0;
        for (int t = 0; t < 9; t++) e[t*DW +: DW] = DW'(v[t]);
        chk(name, act, e);
    endtask

    task automatic clear_stats();
        n_v1 = 0; n_v2 = 0; n_d1 = 0; n_d2 = 0; acc_cnt = 0; first_v1 = -1; mix_bad = 0;
    endtask

    // driver + model + scoreboard for one clock
    task automatic step(input logic en, input logic [DW-1:0] d);
        int r, c;
        logic ev1, ev2, ed;
        logic [TW-1:0] e, got;
        @(negedge clk);
        fifo_enable  = en;
        fifo_data_in = d;
        @(posedge clk);
        #1;
        ev1 = 1'b0; ev2 = 1'b0; ed = 1'b0;
        if (en) begin
            r = pix / IFM;
            c = pix % IFM;
            img[r][c] = d;
            ev1 = (r >= K-1) && (c >= K-1);
            ev2 = ev1 && ((r-(K-1)) % 2 == 0) && ((c-(K-1)) % 2 == 0);
            ed  = (r == IFM-1) && (c == IFM-1);
            if (ev1) begin
                e = '0;
                for (int tr = 0; tr < K; tr++)
                    for (int tc = 0; tc < K; tc++)
                        e[(tr*K+tc)*DW +: DW] = img[r-(K-1)+tr][c-(K-1)+tc];
                exp_q.push_back(e);
                if (ev2) chk("taps_s2", taps2, e);
            end
            pix = (pix + 1) % (IFM*IFM);
            acc_cnt++;
        end
        chk("valid_s1", TW'(valid1), TW'(ev1));
        chk("valid_s2", TW'(valid2), TW'(ev2));
        chk("done_s1", TW'(done1), TW'(ed));
        chk("done_s2", TW'(done2), TW'(ed));
        if (valid1 && exp_q.size() > 0) begin
            got = exp_q.pop_front();
            chk("taps_s1", taps1, got);
        end
        if (!en) begin
            chk("hold_s1", taps1, prev1);
            chk("hold_s2", taps2, prev2);
        end
        if (valid1) begin
            n_v1++;
            if (first_v1 < 0) begin first_v1 = acc_cnt - 1; first_taps1 = taps1; end
            if (acc_cnt - 1 >= 25 && acc_cnt - 1 <= 36) mix_bad++;
        end
        if (valid2) n_v2++;
        if (done1)  n_d1++;
        if (done2)  n_d2++;
        prev1 = taps1;
        prev2 = taps2;
    endtask

    // reset for one edge with fifo_enable high; that pixel must be dropped
    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        fifo_enable  = 1'b1;
        fifo_data_in = 16'hdead;
        @(posedge clk);
        #1;
        chk("rst_valid_s1", TW'(valid1), '0);
        chk("rst_valid_s2", TW'(valid2), '0);
        chk("rst_done_s1", TW'(done1), '0);
        chk("rst_done_s2", TW'(done2), '0);
`ifdef FIFO_RESET_CLEAR_EN
        chk("rst_taps_s1", taps1, '0);
        chk("rst_taps_s2", taps2, '0);
`endif
        @(negedge clk);
        reset       = 1'b0;
        fifo_enable = 1'b0;
        pix = 0;
        exp_q.delete();
        prev1 = taps1;
        prev2 = taps2;
    endtask

    initial begin
        int first_win[9];
        int last_win2[9];
        int naccept;
        first_win = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        last_win2 = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

        for (int i = 0; i < 25; i++) begin
            tbl[i].data = DW'(i);
            tbl[i].v1   = (i inside {12, 13, 14, 17, 18, 19, 22, 23, 24});
            tbl[i].v2   = (i inside {12, 14, 22, 24});
            tbl[i].done = (i == 24);
        end

        // clock / reset
        repeat (2) @(posedge clk);
        do_reset();

        // table-driven: one continuous frame 0..24
        clear_stats();
        for (int i = 0; i < 25; i++) begin
            step(1'b1, tbl[i].data);
            chk("tbl_valid_s1", TW'(valid1), TW'(tbl[i].v1));
            chk("tbl_valid_s2", TW'(valid2), TW'(tbl[i].v2));
            chk("tbl_done_s1", TW'(done1), TW'(tbl[i].done));
            if (i == 12) chk_const("first_window_s1", taps1, first_win);
            if (i == 24) chk_const("last_window_s2", taps2, last_win2);
        end
        chk("count_valid_s1", TW'(n_v1), TW'(9));
        chk("count_valid_s2", TW'(n_v2), TW'(4));

        // enable toggling every other cycle, taps held in gaps
        do_reset();
        clear_stats();
        for (int i = 0; i < 25; i++) begin
            step(1'b1, DW'(i));
            step(1'b0, DW'($urandom));
        end
        chk("gap_count_s1", TW'(n_v1), TW'(9));
        chk("gap_count_s2", TW'(n_v2), TW'(4));
        chk("gap_done_s1", TW'(n_d1), TW'(1));

        // reset mid-frame after pixel 17, then replay
        do_reset();
        for (int i = 0; i < 18; i++) step(1'b1, DW'(i + 100));
        do_reset();
        clear_stats();
        for (int i = 0; i < 25; i++) step(1'b1, DW'(i));
        chk("rst_first_valid_idx", TW'(first_v1), TW'(12));
        chk_const("rst_first_window", first_taps1, first_win);

        // two frames back to back, values 0..49
        do_reset();
        clear_stats();
        for (int i = 0; i < 50; i++) step(1'b1, DW'(i));
        chk("two_frame_valids", TW'(n_v1), TW'(18));
        chk("two_frame_dones_s1", TW'(n_d1), TW'(2));
        chk("two_frame_dones_s2", TW'(n_d2), TW'(2));
        chk("two_frame_no_mix", TW'(mix_bad), '0);

        // randomized data and enable pattern over three frames
        do_reset();
        clear_stats();
        naccept = 0;
        while (naccept < 75) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, DW'($urandom));
                naccept++;
            end else begin
                step(1'b0, DW'($urandom));
            end
        end
        chk("rand_valids_s1", TW'(n_v1), TW'(27));
        chk("rand_valids_s2", TW'(n_v2), TW'(12));
        chk("rand_dones_s1", TW'(n_d1), TW'(3));
        chk("scoreboard_empty", TW'(exp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
